// File: rtl/apu_pkg.sv
// Shared APU definitions: default widths, the silence tone code and the
// lookahead handshake state encoding.
package apu_pkg;
    localparam int TONE_W_DEF = 4;
    localparam int ADDR_W_DEF = 10;

    localparam logic [TONE_W_DEF-1:0] TONE_SILENCE = '0;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ACK       = 2'd1,
        WAIT_DROP = 2'd2
    } la_state_e;
endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with first-word-fall-through head and occupancy count.
// Pushes when full are accepted only alongside a pop; pops when empty are ignored.
module sync_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 14
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push,
    input  logic                   pop,
    input  logic [WIDTH-1:0]       wdata,
    output logic [WIDTH-1:0]       rdata,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q, count_d;
    logic             do_push, do_pop;

    assign full    = (count_q == (PTR_W+1)'(DEPTH));
    assign empty   = (count_q == '0);
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign rdata   = mem_q[rd_ptr_q];
    assign count   = count_q;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = wdata;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        if (do_push && !do_pop) begin
            count_d = count_q + (PTR_W+1)'(1);
        end else if (!do_push && do_pop) begin
            count_d = count_q - (PTR_W+1)'(1);
        end
    end

    // Storage needs no reset: the pointers and count define what is valid.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end
endmodule

// File: rtl/lookahead_sink.sv
// Consumer side of the APU lookahead handshake: captures tone codes into a
// FIFO and releases one per note_clk rising edge to the voice stage.
module lookahead_sink
    import apu_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int TONE_W = TONE_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int CNT_W  = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [TONE_W-1:0]      t3_lookahead,
    input  logic [ADDR_W-1:0]      timestamp,
    input  logic                   lookahead_ready,
    output logic                   acknowledge_lookahead,
    input  logic                   note_clk,
    output logic [TONE_W-1:0]      cur_tone,
    output logic [ADDR_W-1:0]      cur_timestamp,
    output logic                   cur_valid,
    output logic [$clog2(DEPTH):0] fill_level,
    output logic [CNT_W-1:0]       underrun_count
);
    localparam int ENT_W = TONE_W + ADDR_W;

    la_state_e         state_q, state_d;
    logic              note_clk_q, note_clk_d;
    logic [TONE_W-1:0] cur_tone_q, cur_tone_d;
    logic [ADDR_W-1:0] cur_ts_q, cur_ts_d;
    logic              cur_valid_q, cur_valid_d;
    logic [CNT_W-1:0]  underrun_q, underrun_d;

    logic              note_rise, pop, push;
    logic              fifo_full, fifo_empty;
    logic [ENT_W-1:0]  head;

    assign note_rise = note_clk & ~note_clk_q;
    assign pop       = note_rise & ~fifo_empty;
    // A full FIFO still takes the entry when the same cycle frees a slot.
    assign push      = (state_q == IDLE) & lookahead_ready & (~fifo_full | pop);

    sync_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (ENT_W)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .wdata ({t3_lookahead, timestamp}),
        .rdata (head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fill_level)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:      if (push) state_d = ACK;
            ACK:       state_d = WAIT_DROP;
            WAIT_DROP: if (!lookahead_ready) state_d = IDLE;
            default:   state_d = IDLE;
        endcase
    end

    always_comb begin
        note_clk_d  = note_clk;
        cur_tone_d  = cur_tone_q;
        cur_ts_d    = cur_ts_q;
        cur_valid_d = cur_valid_q;
        underrun_d  = underrun_q;
        if (pop) begin
            cur_tone_d  = head[ENT_W-1:ADDR_W];
            cur_ts_d    = head[ADDR_W-1:0];
            cur_valid_d = 1'b1;
        end else if (note_rise) begin
            // Empty at a note boundary: play silence, keep the last timestamp.
            cur_tone_d  = TONE_W'(TONE_SILENCE);
            cur_valid_d = 1'b0;
            if (underrun_q != '1) begin
                underrun_d = underrun_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            note_clk_q  <= 1'b0;
            cur_tone_q  <= '0;
            cur_ts_q    <= '0;
            cur_valid_q <= 1'b0;
            underrun_q  <= '0;
        end else begin
            state_q     <= state_d;
            note_clk_q  <= note_clk_d;
            cur_tone_q  <= cur_tone_d;
            cur_ts_q    <= cur_ts_d;
            cur_valid_q <= cur_valid_d;
            underrun_q  <= underrun_d;
        end
    end

    assign acknowledge_lookahead = (state_q == ACK);
    assign cur_tone              = cur_tone_q;
    assign cur_timestamp         = cur_ts_q;
    assign cur_valid             = cur_valid_q;
    assign underrun_count        = underrun_q;
endmodule

// File: tb/tb_lookahead_sink.sv
// Bench for lookahead_sink: directed table, corner sequences and random traffic
// checked against a queue-based model of the handshake and note release.
module tb_lookahead_sink;
    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] t3 = '0;
    logic [9:0] ts = '0;
    logic       rdy = 1'b0;
    logic       note = 1'b0;

    logic       ack, ack2;
    logic [3:0] tone, tone2;
    logic [9:0] cts, cts2;
    logic       valid, valid2;
    logic [2:0] fill, fill2;
    logic [7:0] under;
    logic [1:0] under2;

    lookahead_sink #(.DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .t3_lookahead(t3), .timestamp(ts),
        .lookahead_ready(rdy), .acknowledge_lookahead(ack), .note_clk(note),
        .cur_tone(tone), .cur_timestamp(cts), .cur_valid(valid),
        .fill_level(fill), .underrun_count(under)
    );

    lookahead_sink #(.DEPTH(DEPTH), .CNT_W(2)) dut_sat (
        .clk(clk), .reset(reset), .t3_lookahead(t3), .timestamp(ts),
        .lookahead_ready(rdy), .acknowledge_lookahead(ack2), .note_clk(note),
        .cur_tone(tone2), .cur_timestamp(cts2), .cur_valid(valid2),
        .fill_level(fill2), .underrun_count(under2)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    // Reference model state
    int mq_tone[$];
    int mq_ts[$];
    bit m_locked, m_ack, m_prev_note, m_valid;
    int m_tone, m_ts, m_under;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cycle(input bit r, input bit rd, input int tn, input int tsv, input bit nt);
        bit rise, pop, push;
        reset = r; rdy = rd; t3 = 4'(tn); ts = 10'(tsv); note = nt;
        rise = nt && !m_prev_note;
        pop  = rise && (mq_tone.size() > 0);
        push = !m_locked && rd && ((mq_tone.size() < DEPTH) || pop);
        @(posedge clk);
        #1;
        if (r) begin
            mq_tone.delete(); mq_ts.delete();
            m_locked = 0; m_ack = 0; m_prev_note = 0; m_valid = 0;
            m_tone = 0; m_ts = 0; m_under = 0;
        end else begin
            if (push) m_locked = 1;
            else if (m_locked && !m_ack && !rd) m_locked = 0;
            m_ack = push;
            if (pop) begin
                m_tone = mq_tone.pop_front();
                m_ts = mq_ts.pop_front();
                m_valid = 1;
            end else if (rise) begin
                m_tone = 0; m_valid = 0; m_under++;
            end
            if (push) begin
                mq_tone.push_back(tn); mq_ts.push_back(tsv);
            end
            m_prev_note = nt;
        end
        chk("ack", int'(ack), int'(m_ack));
        chk("fill", int'(fill), mq_tone.size());
        chk("tone", int'(tone), m_tone);
        chk("ts", int'(cts), m_ts);
        chk("valid", int'(valid), int'(m_valid));
        chk("under", int'(under), (m_under > 255) ? 255 : m_under);
        chk("sat_under", int'(under2), (m_under > 3) ? 3 : m_under);
        chk("sat_fill", int'(fill2), mq_tone.size());
        chk("sat_tone", int'(tone2), m_tone);
    endtask

    typedef struct {
        bit rst; bit rd; int tn; int tsv; bit nt;
        int e_ack; int e_fill; int e_tone; int e_valid; int e_under;
    } vec_t;

    vec_t tbl[17];

    initial begin
        tbl[0]  = '{1,0,0,0,0, 0,0,0,0,0};
        tbl[1]  = '{0,1,5,2,0, 1,1,0,0,0};
        tbl[2]  = '{0,1,5,2,0, 0,1,0,0,0};
        tbl[3]  = '{0,1,5,2,0, 0,1,0,0,0};
        tbl[4]  = '{0,0,0,0,0, 0,1,0,0,0};
        tbl[5]  = '{0,0,0,0,1, 0,0,5,1,0};
        tbl[6]  = '{0,0,0,0,1, 0,0,5,1,0};
        tbl[7]  = '{0,0,0,0,0, 0,0,5,1,0};
        tbl[8]  = '{0,0,0,0,1, 0,0,0,0,1};
        tbl[9]  = '{0,0,0,0,0, 0,0,0,0,1};
        tbl[10] = '{0,0,0,0,1, 0,0,0,0,2};
        tbl[11] = '{0,0,0,0,0, 0,0,0,0,2};
        tbl[12] = '{0,0,0,0,1, 0,0,0,0,3};
        tbl[13] = '{0,0,0,0,0, 0,0,0,0,3};
        tbl[14] = '{0,0,0,0,1, 0,0,0,0,4};
        tbl[15] = '{0,0,0,0,0, 0,0,0,0,4};
        tbl[16] = '{0,0,0,0,1, 0,0,0,0,5};

        for (int i = 0; i < 17; i++) begin
            cycle(tbl[i].rst, tbl[i].rd, tbl[i].tn, tbl[i].tsv, tbl[i].nt);
            chk("tbl_ack", int'(ack), tbl[i].e_ack);
            chk("tbl_fill", int'(fill), tbl[i].e_fill);
            chk("tbl_tone", int'(tone), tbl[i].e_tone);
            chk("tbl_valid", int'(valid), tbl[i].e_valid);
            chk("tbl_under", int'(under), tbl[i].e_under);
        end
        chk("tbl_ts_hold", int'(cts), 2);
        chk("tbl_sat", int'(under2), 3);

        // Fill to DEPTH, then a fifth entry waits until a note edge frees a slot
        for (int i = 1; i <= 4; i++) begin
            cycle(0, 1, i, 100 + i, 0);
            cycle(0, 0, 0, 0, 0);
            cycle(0, 0, 0, 0, 0);
        end
        repeat (3) cycle(0, 1, 5, 105, 0);
        chk("full_fill", int'(fill), 4);
        chk("full_noack", int'(ack), 0);
        cycle(0, 1, 5, 105, 1);
        chk("full_pop_tone", int'(tone), 1);
        chk("full_pop_ack", int'(ack), 1);
        chk("full_pop_fill", int'(fill), 4);
        cycle(0, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 0);

        // Drop to two entries, then push and pop in the same cycle
        cycle(0, 0, 0, 0, 1);
        cycle(0, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 1);
        cycle(0, 0, 0, 0, 0);
        chk("pp_pre_fill", int'(fill), 2);
        cycle(0, 1, 6, 106, 1);
        chk("pp_fill", int'(fill), 2);
        chk("pp_tone", int'(tone), 4);
        cycle(0, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 1);
        chk("pp_next", int'(tone), 5);
        cycle(0, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 1);
        chk("pp_tail", int'(tone), 6);
        cycle(0, 0, 0, 0, 0);

        // Reset while in ACK with three entries held
        cycle(1, 0, 0, 0, 0);
        for (int i = 0; i < 2; i++) begin
            cycle(0, 1, 8 + i, 300 + i, 0);
            cycle(0, 0, 0, 0, 0);
            cycle(0, 0, 0, 0, 0);
        end
        cycle(0, 1, 10, 310, 0);
        chk("rst_pre_ack", int'(ack), 1);
        chk("rst_pre_fill", int'(fill), 3);
        cycle(1, 1, 10, 310, 0);
        chk("rst_ack", int'(ack), 0);
        chk("rst_fill", int'(fill), 0);
        chk("rst_valid", int'(valid), 0);
        cycle(0, 1, 7, 7, 0);
        chk("rst_reaccept", int'(ack), 1);
        chk("rst_refill", int'(fill), 1);
        cycle(0, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 0);

        // Twelve transfers through DEPTH=4 exercise pointer wrap
        cycle(1, 0, 0, 0, 0);
        for (int i = 0; i < 12; i++) begin
            cycle(0, 1, i, 200 + i, 0);
            cycle(0, 0, 0, 0, 1);
            chk("wrap_tone", int'(tone), i);
            chk("wrap_ts", int'(cts), 200 + i);
            cycle(0, 0, 0, 0, 0);
        end
        chk("wrap_under", int'(under), 0);

        // Random traffic against the model
        for (int i = 0; i < 600; i++) begin
            cycle(($urandom_range(0, 99) == 0), ($urandom_range(0, 3) != 0),
                  $urandom_range(0, 15), $urandom_range(0, 1023),
                  ($urandom_range(0, 2) == 0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
